sram_controller: RTL
====================

# sram_controller

Sequences 32-bit load/store requests from the MEM stage onto a 16-bit asynchronous SRAM as two half-word accesses plus fixed wait cycles. It deasserts `ready` while a transaction is in flight, and the pipeline uses `ready` to freeze the stage registers. It sits between the EXE/MEM stage register outputs (`alu_res`, `val_Rm`, `mem_read_en`, `mem_write_en`) and the board SRAM pins. Read data is returned registered to the MEM/WB path.

## Interface
- `WAIT_CYCLES`, 5: total cycles from request acceptance to `ready` high; minimum 3.
- `ADDR_OFFSET`, 1024: byte base subtracted from `address` before SRAM mapping.
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `rd_en` in 1: load request (`mem_read_en`).
- `wr_en` in 1: store request (`mem_write_en`).
- `address` in 32: byte address (`alu_res`).
- `write_data` in 32: store data (`val_Rm`).
- `read_data` out 32: registered load data.
- `ready` out 1: high means no transaction is blocking; the pipeline freezes when low.
- `SRAM_DQ` inout 16: SRAM data bus.
- `SRAM_ADDR` out 18: half-word address.
- `SRAM_WE_N` out 1: write enable, active-low.
- `SRAM_CE_N`, `SRAM_OE_N`, `SRAM_UB_N`, `SRAM_LB_N` out 1 each: tied 0.

## Operation
- FSM states:
  - IDLE: when `rd_en|wr_en`, latch op, word index and `write_data`, then go to ACC_LO.
  - ACC_LO: go to ACC_HI.
  - ACC_HI: go to WAIT if `WAIT_CYCLES`>3, else go to DONE.
  - WAIT: count `WAIT_CYCLES`-3 cycles, then go to DONE.
  - DONE: go to IDLE.
- Word index = `(address - ADDR_OFFSET) >> 2`, truncated to 17 bits.
  - `SRAM_ADDR` = {index, 0} in ACC_LO.
  - `SRAM_ADDR` = {index, 1} in ACC_HI.
  - `SRAM_ADDR` = 0 otherwise.
- Write transaction:
  - ACC_LO drives `SRAM_DQ`=data[15:0] with `SRAM_WE_N`=0.
  - ACC_HI drives `SRAM_DQ`=data[31:16] with `SRAM_WE_N`=0.
  - `SRAM_DQ` is high-Z in all other states and on reads.
- Read transaction:
  - `read_data[15:0]` samples `SRAM_DQ` on the edge leaving ACC_LO.
  - `read_data[31:16]` samples `SRAM_DQ` on the edge leaving ACC_HI.
  - `read_data` holds its value until the next read.
- `ready` is combinational:
  - 0 in IDLE when `rd_en|wr_en`.
  - 0 in ACC_LO, ACC_HI and WAIT.
  - 1 in DONE, and in IDLE with no request.
- Simultaneous `rd_en` and `wr_en`: the write wins; no read occurs.
- Request inputs changing mid-transaction are ignored because the values were latched in IDLE.
- Reset values: state IDLE, `read_data`=0, `SRAM_WE_N`=1, `SRAM_DQ` high-Z, `SRAM_ADDR`=0, wait counter 0.
- Reset mid-transaction aborts immediately. A partial write may leave the low half-word updated; this is accepted.

## Timing
- Request present at cycle 0 (IDLE): ACC_LO at cycle 1, ACC_HI at cycle 2, WAIT at cycles 3..W-1, DONE at cycle W (W=`WAIT_CYCLES`).
- `ready` is low in cycles 0..W-1 and high in cycle W. The stage register captures on the edge ending cycle W.
- `read_data` is valid from cycle 3 onward and stable in DONE.
- Back-to-back requests: a new request seen in the IDLE cycle right after DONE starts the next transaction with no extra gap.

## Configuration
- `SRAM_CTRL_POSTED_WRITE_EN` defined:
  - A write accepted in IDLE keeps `ready`=1 in its acceptance cycle, so the pipeline does not stall. The FSM runs ACC_LO..DONE in the background.
  - Any request arriving while the FSM is not IDLE sees `ready`=0 until the controller returns to IDLE and accepts it.
  - Reads always stall.
- Undefined: every write stalls exactly as a read, per Timing.

## Structure
- Package `sram_ctrl_pkg` holds:
  - the state enum (IDLE, ACC_LO, ACC_HI, WAIT, DONE);
  - `SRAM_DW`=16 and `SRAM_AW`=18;
  - the default `WAIT_CYCLES` and `ADDR_OFFSET`.
- One sub-module, `sram_wait_counter`: loadable down-counter with a `zero` flag, used by WAIT.

## Test plan
- Write 0xDEADBEEF to address 1024 → ACC_LO drives ADDR 0, DQ 0xBEEF, WE_N 0; ACC_HI drives ADDR 1, DQ 0xDEAD; `ready` is low 5 cycles and high in cycle 5.
- Read address 1024 with an SRAM model holding 0xBEEF/0xDEAD → `read_data`=0xDEADBEEF in DONE; `SRAM_DQ` is never driven by the DUT.
- Write 0x12345678 to 1028, then read 1028 back-to-back → second transaction starts the cycle after DONE; read returns 0x12345678; SRAM_ADDR shows 2 and 3.
- `rd_en`=`wr_en`=1 with address 1032 and data 0xA5A5_5A5A → only a write occurs; `read_data` is unchanged.
- Assert `rst` during ACC_HI of a write → next cycle state is IDLE, WE_N=1, DQ high-Z, `read_data`=0, `ready`=1 with no request.
- With `SRAM_CTRL_POSTED_WRITE_EN` defined: write then immediate read → `ready` stays 1 for the write. `ready` is 0 for the read until the write's DONE, then the read completes with W more stall cycles.

Source files
------------

// File: rtl/sram_ctrl_pkg.sv
// Shared types and constants for the 32-bit to 16-bit asynchronous SRAM controller.
package sram_ctrl_pkg;

  localparam int SRAM_DW         = 16;
  localparam int SRAM_AW         = 18;
  localparam int DEF_WAIT_CYCLES = 5;
  localparam int DEF_ADDR_OFFSET = 1024;

  typedef enum logic [2:0] {S_IDLE, S_ACC_LO, S_ACC_HI, S_WAIT, S_DONE} state_t;

  // Byte address to 32-bit word index inside the SRAM window.
  function automatic logic [SRAM_AW-2:0] word_index(input logic [31:0] addr,
                                                    input logic [31:0] ofs);
    logic [31:0] rel;
    rel = (addr - ofs) >> 2;
    return rel[SRAM_AW-2:0];
  endfunction

endpackage

// File: rtl/sram_wait_counter.sv
// Loadable down-counter that holds at zero; paces the WAIT state of the SRAM controller.
module sram_wait_counter #(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          dec,
  input  logic [CW-1:0] load_val,
  output logic          zero
);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                   cnt <= '0;
    else if (load)             cnt <= load_val;
    else if (dec && cnt != '0) cnt <= cnt - 1'b1;
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/sram_controller.sv
// MEM-stage 32-bit load/store sequencer onto a 16-bit async SRAM (two half-word beats + wait).
// Optional SRAM_CTRL_POSTED_WRITE_EN: writes accepted from IDLE do not stall the pipeline.
module sram_controller
  import sram_ctrl_pkg::*;
#(
  parameter int WAIT_CYCLES = DEF_WAIT_CYCLES,
  parameter int ADDR_OFFSET = DEF_ADDR_OFFSET
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rd_en,
  input  logic               wr_en,
  input  logic [31:0]        address,
  input  logic [31:0]        write_data,
  output logic [31:0]        read_data,
  output logic               ready,
  inout  wire  [SRAM_DW-1:0] SRAM_DQ,
  output logic [SRAM_AW-1:0] SRAM_ADDR,
  output logic               SRAM_WE_N,
  output logic               SRAM_CE_N,
  output logic               SRAM_OE_N,
  output logic               SRAM_UB_N,
  output logic               SRAM_LB_N
);

  localparam int CW        = (WAIT_CYCLES > 4) ? $clog2(WAIT_CYCLES) : 2;
  localparam int WAIT_LOAD = (WAIT_CYCLES > 3) ? WAIT_CYCLES - 4 : 0;
`ifdef SRAM_CTRL_POSTED_WRITE_EN
  localparam bit POSTED = 1'b1;
`else
  localparam bit POSTED = 1'b0;
`endif

  state_t               state, state_nxt;
  logic                 req, accept, cnt_zero;
  logic                 op_wr, posted_q;
  logic [SRAM_AW-2:0]   idx;
  logic [31:0]          wdata;
  logic                 dq_oe;
  logic [SRAM_DW-1:0]   dq_out;

  assign req    = rd_en | wr_en;
  assign accept = (state == S_IDLE) && req;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (req) state_nxt = S_ACC_LO;
      S_ACC_LO: state_nxt = S_ACC_HI;
      S_ACC_HI: state_nxt = (WAIT_CYCLES > 3) ? S_WAIT : S_DONE;
      S_WAIT:   if (cnt_zero) state_nxt = S_DONE;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    SRAM_ADDR = '0;
    SRAM_WE_N = 1'b1;
    dq_oe     = 1'b0;
    dq_out    = '0;
    ready     = 1'b0;
    case (state)
      // Posted writes keep ready high in IDLE; a lone read always stalls.
      S_IDLE:   ready = POSTED ? !(rd_en && !wr_en) : !req;
      S_ACC_LO: begin
        SRAM_ADDR = {idx, 1'b0};
        SRAM_WE_N = !op_wr;
        dq_oe     = op_wr;
        dq_out    = wdata[15:0];
      end
      S_ACC_HI: begin
        SRAM_ADDR = {idx, 1'b1};
        SRAM_WE_N = !op_wr;
        dq_oe     = op_wr;
        dq_out    = wdata[31:16];
      end
      // After a posted write the pipeline has moved on, so a pending request must wait.
      S_DONE:   ready = posted_q ? !req : 1'b1;
      default:  ready = 1'b0;
    endcase
  end

  assign SRAM_DQ   = dq_oe ? dq_out : {SRAM_DW{1'bz}};
  assign SRAM_CE_N = 1'b0;
  assign SRAM_OE_N = 1'b0;
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_wr    <= 1'b0;
      posted_q <= 1'b0;
      idx      <= '0;
      wdata    <= '0;
    end else if (accept) begin
      op_wr    <= wr_en;
      posted_q <= POSTED && wr_en;
      idx      <= word_index(address, 32'(ADDR_OFFSET));
      wdata    <= write_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) read_data <= '0;
    else if (!op_wr && state == S_ACC_LO) read_data[15:0]  <= SRAM_DQ;
    else if (!op_wr && state == S_ACC_HI) read_data[31:16] <= SRAM_DQ;
  end

  sram_wait_counter #(.CW(CW)) u_wait (
    .clk      (clk),
    .rst      (rst),
    .load     (state == S_ACC_HI),
    .dec      (state == S_WAIT),
    .load_val (CW'(WAIT_LOAD)),
    .zero     (cnt_zero)
  );

endmodule
